// File: rtl/serv_pkg.sv
// Shared state encoding, access-size codes and lane helpers for the serial data buffer.
package serv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    REQ   = 3'd2,
    SHIFT = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] sel_mask(input logic [1:0] size, input logic [1:0] lsb);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << lsb;
      SZ_H:    m = 4'b0011 << {lsb[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Number of meaningful load bits for an access size; reserved codes act as word.
  function automatic logic [6:0] size_bits(input logic [1:0] size);
    logic [6:0] n;
    case (size)
      SZ_B:    n = 7'd8;
      SZ_H:    n = 7'd16;
      default: n = 7'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/serv_datbuf_ext.sv
// Load lane selector: passes loaded bits while inside the access width, sign/zero fill beyond it.
module serv_datbuf_ext
  import serv_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] i_dat,
  input  logic [5:0]                i_bitcnt,
  input  logic [1:0]                i_size,
  input  logic                      i_sext,
  output logic [BITS_PER_CYCLE-1:0] o_q
);

  logic [6:0] w_limit;

  assign w_limit = size_bits(i_size);

  // Each output bit comes from the data while its bit position is below the access width.
  always_comb begin
    o_q = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      o_q[k] = (({1'b0, i_bitcnt} + 7'(k)) < w_limit) ? i_dat[k] : i_sext;
    end
  end

endmodule

// File: rtl/serv_datbuf.sv
// Serial data buffer: operand fill, memory bus handshake, shift counting and load drain.
module serv_datbuf
  import serv_pkg::*;
#(
  parameter  int BITS_PER_CYCLE = 1,
  localparam int LB = $clog2(BITS_PER_CYCLE)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_init,
  input  logic                      i_cnt_done,
  input  logic [1:0]                i_lsb,
  input  logic                      i_op_b_sel,
  input  logic                      i_shift_op,
  input  logic                      i_right_shift_op,
  input  logic                      i_mem_op,
  input  logic                      i_mem_we,
  input  logic [1:0]                i_mem_size,
  input  logic                      i_mem_signed,
  input  logic [BITS_PER_CYCLE-1:0] i_rs2,
  input  logic [BITS_PER_CYCLE-1:0] i_imm,
  output logic [BITS_PER_CYCLE-1:0] o_op_b,
  output logic [BITS_PER_CYCLE-1:0] o_q,
  output logic                      o_sh_done,
  output logic                      o_sh_done_r,
  output logic [LB:0]               o_shift_counter_lsb,
  output logic                      o_wb_cyc,
  output logic [31:0]               o_wb_dat,
  output logic [3:0]                o_wb_sel,
  input  logic                      i_wb_ack,
  input  logic [31:0]               i_wb_rdt,
  output logic                      o_busy
);

  localparam int         B        = BITS_PER_CYCLE;
  localparam logic [5:0] STEP     = 6'(B);
  localparam logic [5:0] LSB_MASK = 6'(B - 1);

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_dat;
  logic          r_sext;
  logic [5:0]    r_bitcnt;
  logic          r_sh_first;
  logic          r_sh_done_r;

  logic          w_fill_step;
  logic [31:0]   w_fill_dat;
  logic [31:0]   w_rdt_sh;
  logic          w_ld_sext;
  logic          w_sh_hold;
  logic [5:0]    w_sh_next;
  logic [6:0]    w_bitcnt_sum;
  logic [5:0]    w_bitcnt_inc;
  logic [B-1:0]  w_ext_q;

  assign o_op_b = i_op_b_sel ? i_rs2 : i_imm;

  // An init step shifts operand data in from any state, which is also how an access is aborted.
  assign w_fill_step = i_en & ((r_state == FILL) | i_init);

  assign w_rdt_sh = i_wb_rdt >> {i_lsb, 3'b000};

  // A right shift whose amount is not a multiple of B spends its first cycle on the partial shift.
  assign w_sh_hold = r_sh_first & i_right_shift_op & ((r_dat[5:0] & LSB_MASK) != 6'd0);
  assign w_sh_next = w_sh_hold ? r_dat[5:0] : (r_dat[5:0] - STEP);

  assign o_sh_done           = (r_state == SHIFT) & w_sh_next[5];
  assign o_sh_done_r         = r_sh_done_r;
  assign o_shift_counter_lsb = (LB + 1)'(r_dat[5:0] & LSB_MASK);

  assign w_bitcnt_sum = {1'b0, r_bitcnt} + 7'(B);
  assign w_bitcnt_inc = (w_bitcnt_sum > 7'd32) ? 6'd32 : w_bitcnt_sum[5:0];

  // Shift in the next operand slice; only a shift consumes the low bits as a counter, so only then is its sign bit cleared.
  always_comb begin
    w_fill_dat = {o_op_b, r_dat[31:B]};
    if (i_cnt_done & ~i_mem_op & i_shift_op) begin
      w_fill_dat[5] = 1'b0;
    end
  end

  // Extension bit of a load is the top bit of the addressed byte or half, or bit 31 for a word.
  always_comb begin
    case (i_mem_size)
      SZ_B:    w_ld_sext = w_rdt_sh[7];
      SZ_H:    w_ld_sext = w_rdt_sh[15];
      SZ_W:    w_ld_sext = i_wb_rdt[31];
      default: w_ld_sext = i_wb_rdt[31];
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; an init step overrides everything, so a late ack during abort is dropped.
  always_comb begin
    w_next = r_state;
    if (w_fill_step) begin
      if (i_cnt_done) begin
        if (i_mem_op) begin
          w_next = REQ;
        end else if (i_shift_op) begin
          w_next = SHIFT;
        end else begin
          w_next = IDLE;
        end
      end else begin
        w_next = FILL;
      end
    end else begin
      case (r_state)
        REQ:     if (i_wb_ack) w_next = i_mem_we ? IDLE : DRAIN;
        SHIFT:   if (i_en & i_cnt_done) w_next = IDLE;
        DRAIN:   if (i_en & i_cnt_done) w_next = IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  // Bus, busy and serial result outputs derived from the current state.
  always_comb begin
    o_busy   = (r_state != IDLE);
    o_wb_cyc = (r_state == REQ);
    o_wb_sel = 4'b0000;
    o_q      = r_dat[{i_lsb, 3'b000} +: B];
    case (i_mem_size)
      SZ_B:    o_wb_dat = {4{r_dat[7:0]}};
      SZ_H:    o_wb_dat = {2{r_dat[15:0]}};
      default: o_wb_dat = r_dat;
    endcase
    if (r_state == REQ) begin
      o_wb_sel = sel_mask(i_mem_size, i_lsb);
    end
    if (r_state == DRAIN) begin
      o_q = w_ext_q;
    end
  end

  // Data word, load extension bit and drain bit counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dat    <= 32'd0;
      r_sext   <= 1'b0;
      r_bitcnt <= 6'd0;
    end else if (w_fill_step) begin
      r_dat    <= w_fill_dat;
      r_bitcnt <= 6'd0;
    end else begin
      case (r_state)
        REQ: begin
          if (i_wb_ack & ~i_mem_we) begin
            r_dat    <= w_rdt_sh;
            r_sext   <= i_mem_signed & w_ld_sext;
            r_bitcnt <= 6'd0;
          end
        end
        SHIFT: begin
          r_dat[5:0] <= w_sh_next;
        end
        DRAIN: begin
          if (i_en) begin
            r_dat    <= r_dat >> B;
            r_bitcnt <= w_bitcnt_inc;
          end
        end
        default: begin
          r_dat <= r_dat;
        end
      endcase
    end
  end

  // First-shift-cycle marker and the registered copy of the counter sign bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh_first  <= 1'b0;
      r_sh_done_r <= 1'b0;
    end else begin
      r_sh_first  <= (w_next == SHIFT) & (r_state != SHIFT);
      r_sh_done_r <= (r_state == SHIFT) & (w_next == SHIFT) & w_sh_next[5];
    end
  end

  serv_datbuf_ext #(
    .BITS_PER_CYCLE (B)
  ) u_ext (
    .i_dat    (r_dat[B-1:0]),
    .i_bitcnt (r_bitcnt),
    .i_size   (i_mem_size),
    .i_sext   (r_sext),
    .o_q      (w_ext_q)
  );

endmodule

// File: tb/tb_serv_datbuf.sv
// Directed bench for serv_datbuf: a B=1 and a B=4 instance share control inputs.
module tb_serv_datbuf;
  import serv_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        init;
  logic        cnt_done;
  logic [1:0]  lsb;
  logic        op_b_sel;
  logic        shift_op;
  logic        right_op;
  logic        mem_op;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic        ack;
  logic [31:0] rdt;

  logic        rs2_1, imm_1;
  logic [3:0]  rs2_4, imm_4;

  logic        op_b1, q1, sh_done1, sh_done_r1, cyc1, busy1;
  logic [0:0]  scl1;
  logic [31:0] dat1;
  logic [3:0]  sel1;

  logic [3:0]  op_b4, q4;
  logic        sh_done4, sh_done_r4, cyc4, busy4;
  logic [2:0]  scl4;
  logic [31:0] dat4;
  logic [3:0]  sel4;

  int          checks;
  int          failures;
  logic [31:0] got;

  serv_datbuf #(.BITS_PER_CYCLE(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
    .i_lsb(lsb), .i_op_b_sel(op_b_sel), .i_shift_op(shift_op),
    .i_right_shift_op(right_op), .i_mem_op(mem_op), .i_mem_we(mem_we),
    .i_mem_size(mem_size), .i_mem_signed(mem_signed), .i_rs2(rs2_1), .i_imm(imm_1),
    .o_op_b(op_b1), .o_q(q1), .o_sh_done(sh_done1), .o_sh_done_r(sh_done_r1),
    .o_shift_counter_lsb(scl1), .o_wb_cyc(cyc1), .o_wb_dat(dat1), .o_wb_sel(sel1),
    .i_wb_ack(ack), .i_wb_rdt(rdt), .o_busy(busy1)
  );

  serv_datbuf #(.BITS_PER_CYCLE(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
    .i_lsb(lsb), .i_op_b_sel(op_b_sel), .i_shift_op(shift_op),
    .i_right_shift_op(right_op), .i_mem_op(mem_op), .i_mem_we(mem_we),
    .i_mem_size(mem_size), .i_mem_signed(mem_signed), .i_rs2(rs2_4), .i_imm(imm_4),
    .o_op_b(op_b4), .o_q(q4), .o_sh_done(sh_done4), .o_sh_done_r(sh_done_r4),
    .o_shift_counter_lsb(scl4), .o_wb_cyc(cyc4), .o_wb_dat(dat4), .o_wb_sel(sel4),
    .i_wb_ack(ack), .i_wb_rdt(rdt), .o_busy(busy4)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Pulse reset across one clock edge.
  task automatic doReset();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
  endtask

  // Feed a 32-bit operand LSB-first through the init phase of the selected instance.
  task automatic fillWord(input int bpc, input logic [31:0] word);
    int beats;
    beats = 32 / bpc;
    for (int i = 0; i < beats; i++) begin
      en       = 1'b1;
      init     = 1'b1;
      cnt_done = (i == beats - 1);
      if (bpc == 4) begin
        rs2_4 = word[4*i +: 4];
        imm_4 = word[4*i +: 4];
      end else begin
        rs2_1 = word[i];
        imm_1 = word[i];
      end
      if (i == beats - 1) begin
        #1;
        if (bpc == 4) checkOutput("cyc_low_during_fill4", 32'(cyc4), 32'd0);
        else          checkOutput("cyc_low_during_fill1", 32'(cyc1), 32'd0);
      end
      applyStimulus();
    end
    en       = 1'b0;
    init     = 1'b0;
    cnt_done = 1'b0;
  endtask

  // Linear directed sequence.
  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 0; init = 0; cnt_done = 0; lsb = 0; op_b_sel = 0;
    shift_op = 0; right_op = 0; mem_op = 0; mem_we = 0; mem_size = SZ_B;
    mem_signed = 0; ack = 0; rdt = 32'd0; rs2_1 = 0; imm_1 = 0; rs2_4 = 0; imm_4 = 0;

    #2;
    checkOutput("rst_cyc4", 32'(cyc4), 32'd0);
    checkOutput("rst_sel4", 32'(sel4), 32'd0);
    checkOutput("rst_q4", 32'(q4), 32'd0);
    checkOutput("rst_busy4", 32'(busy4), 32'd0);
    checkOutput("rst_shdr4", 32'(sh_done_r4), 32'd0);
    checkOutput("rst_cyc1", 32'(cyc1), 32'd0);
    checkOutput("rst_busy1", 32'(busy1), 32'd0);
    applyStimulus();
    rst = 1'b0;

    // Operand mux.
    rs2_4 = 4'hA; imm_4 = 4'h5; rs2_1 = 1'b1; imm_1 = 1'b0;
    op_b_sel = 1'b1; #1;
    checkOutput("opb_rs2_4", 32'(op_b4), 32'hA);
    checkOutput("opb_rs2_1", 32'(op_b1), 32'h1);
    op_b_sel = 1'b0; #1;
    checkOutput("opb_imm_4", 32'(op_b4), 32'h5);
    checkOutput("opb_imm_1", 32'(op_b1), 32'h0);

    // B=1 store byte 0xA5 at offset 2.
    doReset();
    op_b_sel = 1; mem_op = 1; mem_we = 1; mem_size = SZ_B; lsb = 2'd2; shift_op = 0;
    fillWord(1, 32'h000000A5);
    checkOutput("sb_cyc_rise", 32'(cyc1), 32'd1);
    checkOutput("sb_dat", dat1, 32'hA5A5A5A5);
    checkOutput("sb_sel", 32'(sel1), 32'h4);
    applyStimulus();
    checkOutput("sb_cyc_hold", 32'(cyc1), 32'd1);
    checkOutput("sb_dat_hold", dat1, 32'hA5A5A5A5);
    ack = 1'b1;
    applyStimulus();
    ack = 1'b0;
    checkOutput("sb_cyc_drop", 32'(cyc1), 32'd0);
    checkOutput("sb_busy_idle", 32'(busy1), 32'd0);
    checkOutput("sb_sel_idle", 32'(sel1), 32'd0);
    lsb = 2'd0; #1;
    checkOutput("idle_q_lsb0", 32'(q1), 32'd1);
    lsb = 2'd1; #1;
    checkOutput("idle_q_lsb1", 32'(q1), 32'd0);

    // B=4 signed byte load from offset 1.
    doReset();
    op_b_sel = 1; mem_op = 1; mem_we = 0; mem_size = SZ_B; mem_signed = 1; lsb = 2'd1;
    fillWord(4, 32'h0);
    checkOutput("lb_cyc", 32'(cyc4), 32'd1);
    checkOutput("lb_sel", 32'(sel4), 32'h2);
    rdt = 32'h0000F300; ack = 1'b1;
    applyStimulus();
    ack = 1'b0; rdt = 32'h0;
    checkOutput("lb_first_nibble", 32'(q4), 32'h3);
    got = 32'd0;
    for (int i = 0; i < 8; i++) begin
      got[4*i +: 4] = q4;
      en = 1'b1; cnt_done = (i == 7);
      applyStimulus();
    end
    en = 1'b0; cnt_done = 1'b0;
    checkOutput("lb_drained", got, 32'hFFFFFFF3);
    checkOutput("lb_busy_end", 32'(busy4), 32'd0);

    // Same stimulus, unsigned.
    doReset();
    mem_signed = 0;
    fillWord(4, 32'h0);
    rdt = 32'h0000F300; ack = 1'b1;
    applyStimulus();
    ack = 1'b0; rdt = 32'h0;
    got = 32'd0;
    for (int i = 0; i < 8; i++) begin
      got[4*i +: 4] = q4;
      en = 1'b1; cnt_done = (i == 7);
      applyStimulus();
    end
    en = 1'b0; cnt_done = 1'b0;
    checkOutput("lbu_drained", got, 32'h000000F3);

    // Async reset in the middle of a signed drain.
    doReset();
    mem_signed = 1;
    fillWord(4, 32'h0);
    rdt = 32'h0000F300; ack = 1'b1;
    applyStimulus();
    ack = 1'b0; rdt = 32'h0;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1;
      applyStimulus();
    end
    en = 1'b0; #1;
    checkOutput("drain_mid_q", 32'(q4), 32'hF);
    checkOutput("drain_mid_busy", 32'(busy4), 32'd1);
    rst = 1'b1; #1;
    checkOutput("async_rst_cyc", 32'(cyc4), 32'd0);
    checkOutput("async_rst_busy", 32'(busy4), 32'd0);
    checkOutput("async_rst_q", 32'(q4), 32'd0);
    rst = 1'b0;

    // B=4 logical right shift by 6.
    doReset();
    mem_op = 0; mem_we = 0; mem_signed = 0; shift_op = 1; right_op = 1; op_b_sel = 0; lsb = 2'd0;
    fillWord(4, 32'h00000006);
    checkOutput("srl_busy", 32'(busy4), 32'd1);
    checkOutput("srl_cnt_lsb", 32'(scl4), 32'd2);
    checkOutput("srl_done_c0", 32'(sh_done4), 32'd0);
    applyStimulus();
    checkOutput("srl_done_c1", 32'(sh_done4), 32'd0);
    checkOutput("srl_cnt_held", 32'(scl4), 32'd2);
    applyStimulus();
    checkOutput("srl_done_c2", 32'(sh_done4), 32'd1);
    checkOutput("srl_done_r_c2", 32'(sh_done_r4), 32'd0);
    applyStimulus();
    checkOutput("srl_done_r_c3", 32'(sh_done_r4), 32'd1);
    en = 1'b1; cnt_done = 1'b1;
    applyStimulus();
    en = 1'b0; cnt_done = 1'b0;
    checkOutput("srl_exit_idle", 32'(busy4), 32'd0);

    // B=1 left shift by 0.
    doReset();
    shift_op = 1; right_op = 0;
    fillWord(1, 32'h0);
    checkOutput("sll0_busy", 32'(busy1), 32'd1);
    checkOutput("sll0_done", 32'(sh_done1), 32'd1);
    en = 1'b1; cnt_done = 1'b1;
    applyStimulus();
    en = 1'b0; cnt_done = 1'b0;
    shift_op = 0;

    // B=4 abort during a word load request with a simultaneous ack.
    doReset();
    op_b_sel = 1; mem_op = 1; mem_we = 0; mem_size = SZ_W; lsb = 2'd0;
    fillWord(4, 32'h12345678);
    checkOutput("abort_req_cyc", 32'(cyc4), 32'd1);
    checkOutput("abort_req_dat", dat4, 32'h12345678);
    checkOutput("abort_req_sel", 32'(sel4), 32'hF);
    en = 1'b1; init = 1'b1; cnt_done = 1'b0; rs2_4 = 4'h9; ack = 1'b1; rdt = 32'hDEADBEEF;
    applyStimulus();
    ack = 1'b0; rdt = 32'h0; en = 1'b0; init = 1'b0; #1;
    checkOutput("abort_cyc_drop", 32'(cyc4), 32'd0);
    checkOutput("abort_busy", 32'(busy4), 32'd1);
    checkOutput("abort_q_no_rdt", 32'(q4), 32'h7);
    mem_we = 1'b1;
    got = 32'h3C5A7E19;
    for (int i = 1; i < 8; i++) begin
      en = 1'b1; init = 1'b1; cnt_done = (i == 7);
      rs2_4 = got[4*i +: 4];
      applyStimulus();
    end
    en = 1'b0; init = 1'b0; cnt_done = 1'b0;
    checkOutput("refill_cyc", 32'(cyc4), 32'd1);
    checkOutput("refill_dat", dat4, 32'h3C5A7E19);
    ack = 1'b1;
    applyStimulus();
    ack = 1'b0;
    checkOutput("refill_store_idle", 32'(busy4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
